// File: rtl/apb_bridge_pkg.sv
// Shared types and default widths for the APB bridge/router family.
// Read by apb_slave_router (optional watchdog macro: APB_ROUTER_TIMEOUT_EN).
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int DEF_ADDR_WD = 8;
    localparam int DEF_DATA_WD = 8;
    localparam int DEF_STRB_WD = 2;
    localparam int DEF_PROT_WD = 4;
    localparam int DEF_NUM_SLV = 4;
    localparam int DEF_SEL_WD  = 2;
    localparam int DEF_TIMEOUT = 16;

    // Read data returned to the master on unmapped or aborted transfers.
    localparam int RESP_ERR_DATA = 0;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decode from the top address bits: index, one-hot select
// and a flag telling whether the index names an existing slave.
module apb_addr_decode #(
    parameter int SEL_WD  = 2,
    parameter int NUM_SLV = 4
) (
    input  logic [SEL_WD-1:0]  paddr_msb,
    output logic [SEL_WD-1:0]  idx,
    output logic [NUM_SLV-1:0] onehot,
    output logic               mapped
);

    assign idx    = paddr_msb;
    assign mapped = (int'(paddr_msb) < NUM_SLV);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_onehot
            assign onehot[gi] = (paddr_msb == SEL_WD'(gi));
        end
    endgenerate

endmodule

// File: rtl/apb_slave_router.sv
// APB4 one-to-many router with registered slave-side outputs and PSLVERR on
// unmapped addresses. Define APB_ROUTER_TIMEOUT_EN to enable the hung-slave watchdog.
module apb_slave_router
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WD = DEF_ADDR_WD,
    parameter int DATA_WD = DEF_DATA_WD,
    parameter int STRB_WD = DEF_STRB_WD,
    parameter int PROT_WD = DEF_PROT_WD,
    parameter int NUM_SLV = DEF_NUM_SLV,
    parameter int SEL_WD  = DEF_SEL_WD,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       pclk,
    input  logic                       prst,
    input  logic                       m_psel,
    input  logic                       m_penable,
    input  logic                       m_pwrite,
    input  logic [ADDR_WD-1:0]         m_paddr,
    input  logic [DATA_WD-1:0]         m_pwdata,
    input  logic [PROT_WD-1:0]         m_pprot,
    input  logic [STRB_WD-1:0]         m_pstrb,
    output logic [DATA_WD-1:0]         m_prdata,
    output logic                       m_pready,
    output logic                       m_pslverr,
    output logic [NUM_SLV-1:0]         s_psel,
    output logic                       s_penable,
    output logic                       s_pwrite,
    output logic [ADDR_WD-1:0]         s_paddr,
    output logic [DATA_WD-1:0]         s_pwdata,
    output logic [PROT_WD-1:0]         s_pprot,
    output logic [STRB_WD-1:0]         s_pstrb,
    input  logic [NUM_SLV*DATA_WD-1:0] s_prdata,
    input  logic [NUM_SLV-1:0]         s_pready,
    input  logic [NUM_SLV-1:0]         s_pslverr
);

    generate
        if (NUM_SLV < 2 || NUM_SLV > (2 ** SEL_WD)) begin : g_bad_num_slv
            $error("apb_slave_router: NUM_SLV out of range");
        end
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("apb_slave_router: TIMEOUT must be at least 2");
        end
    endgenerate

    apb_state_e state_reg, state_next;

    logic [SEL_WD-1:0]  dec_idx;
    logic [NUM_SLV-1:0] dec_onehot;
    logic               dec_mapped;
    logic               capture;

    logic [SEL_WD-1:0]  idx_reg;
    logic [NUM_SLV-1:0] s_psel_reg, s_psel_next;
    logic               s_penable_reg, s_penable_next;
    logic               s_pwrite_reg;
    logic [ADDR_WD-1:0] s_paddr_reg;
    logic [DATA_WD-1:0] s_pwdata_reg;
    logic [PROT_WD-1:0] s_pprot_reg;
    logic [STRB_WD-1:0] s_pstrb_reg;

    logic               m_pready_reg;
    logic [DATA_WD-1:0] m_prdata_reg, m_prdata_next;
    logic               m_pslverr_reg, m_pslverr_next;

    logic               sel_ready;
    logic               sel_err;
    logic [DATA_WD-1:0] sel_rdata;
    logic               timeout_hit;

    apb_addr_decode #(
        .SEL_WD  (SEL_WD),
        .NUM_SLV (NUM_SLV)
    ) u_decode (
        .paddr_msb (m_paddr[ADDR_WD-1 -: SEL_WD]),
        .idx       (dec_idx),
        .onehot    (dec_onehot),
        .mapped    (dec_mapped)
    );

    // Only the captured slave's response lines are looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_reg == SEL_WD'(i)) begin
                sel_ready = s_pready[i];
                sel_err   = s_pslverr[i];
                sel_rdata = s_prdata[i*DATA_WD +: DATA_WD];
            end
        end
    end

`ifdef APB_ROUTER_TIMEOUT_EN
    localparam int CNT_WD = $clog2(TIMEOUT + 1);

    logic [CNT_WD-1:0] cnt_reg;

    always_ff @(posedge pclk) begin
        if (prst) begin
            cnt_reg <= '0;
        end else if (state_reg == SETUP) begin
            cnt_reg <= '0;
        end else if (state_reg == ACCESS) begin
            cnt_reg <= cnt_reg + CNT_WD'(1);
        end
    end

    assign timeout_hit = (state_reg == ACCESS) && (cnt_reg == CNT_WD'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        capture        = 1'b0;
        s_psel_next    = s_psel_reg;
        s_penable_next = 1'b0;
        m_prdata_next  = m_prdata_reg;
        m_pslverr_next = m_pslverr_reg;
        case (state_reg)
            IDLE: begin
                if (m_psel && !m_penable) begin
                    capture = 1'b1;
                    if (dec_mapped) begin
                        state_next  = SETUP;
                        s_psel_next = dec_onehot;
                    end else begin
                        state_next     = RESP;
                        s_psel_next    = '0;
                        m_prdata_next  = DATA_WD'(RESP_ERR_DATA);
                        m_pslverr_next = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_next     = ACCESS;
                s_penable_next = 1'b1;
            end
            ACCESS: begin
                // A ready slave wins over a watchdog expiry in the same cycle.
                if (sel_ready) begin
                    state_next     = RESP;
                    s_psel_next    = '0;
                    m_pslverr_next = sel_err;
                    m_prdata_next  = s_pwrite_reg ? '0 : sel_rdata;
                end else if (timeout_hit) begin
                    state_next     = RESP;
                    s_psel_next    = '0;
                    m_pslverr_next = 1'b1;
                    m_prdata_next  = DATA_WD'(RESP_ERR_DATA);
                end else begin
                    s_penable_next = 1'b1;
                end
            end
            RESP: begin
                state_next  = IDLE;
                s_psel_next = '0;
            end
            default: begin
                state_next  = IDLE;
                s_psel_next = '0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            s_psel_reg    <= '0;
            s_penable_reg <= 1'b0;
            s_pwrite_reg  <= 1'b0;
            s_paddr_reg   <= '0;
            s_pwdata_reg  <= '0;
            s_pprot_reg   <= '0;
            s_pstrb_reg   <= '0;
            m_pready_reg  <= 1'b0;
            m_prdata_reg  <= '0;
            m_pslverr_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            s_psel_reg    <= s_psel_next;
            s_penable_reg <= s_penable_next;
            m_pready_reg  <= (state_next == RESP);
            m_prdata_reg  <= m_prdata_next;
            m_pslverr_reg <= m_pslverr_next;
            // Unmapped transfers leave the slave-side buses untouched.
            if (capture && dec_mapped) begin
                idx_reg      <= dec_idx;
                s_pwrite_reg <= m_pwrite;
                s_paddr_reg  <= m_paddr;
                s_pwdata_reg <= m_pwdata;
                s_pprot_reg  <= m_pprot;
                s_pstrb_reg  <= m_pwrite ? m_pstrb : '0;
            end
        end
    end

    assign s_psel    = s_psel_reg;
    assign s_penable = s_penable_reg;
    assign s_pwrite  = s_pwrite_reg;
    assign s_paddr   = s_paddr_reg;
    assign s_pwdata  = s_pwdata_reg;
    assign s_pprot   = s_pprot_reg;
    assign s_pstrb   = s_pstrb_reg;
    assign m_pready  = m_pready_reg;
    assign m_prdata  = m_prdata_reg;
    assign m_pslverr = m_pslverr_reg;

endmodule

// File: tb/tb_apb_slave_router.sv
// Directed bench for apb_slave_router: a 4-slave router for the main flows and a
// 3-slave router sharing the master bus for the unmapped-address case.
module tb_apb_slave_router;

    logic        pclk;
    logic        prst;
    logic        m_psel, m_penable, m_pwrite;
    logic [7:0]  m_paddr, m_pwdata;
    logic [3:0]  m_pprot;
    logic [1:0]  m_pstrb;

    logic [7:0]  m_prdata;
    logic        m_pready, m_pslverr;
    logic [3:0]  s_psel;
    logic        s_penable, s_pwrite;
    logic [7:0]  s_paddr, s_pwdata;
    logic [3:0]  s_pprot;
    logic [1:0]  s_pstrb;
    logic [31:0] s_prdata;
    logic [3:0]  s_pready, s_pslverr;

    logic [7:0]  m_prdata3;
    logic        m_pready3, m_pslverr3;
    logic [2:0]  s_psel3;
    logic        s_penable3, s_pwrite3;
    logic [7:0]  s_paddr3, s_pwdata3;
    logic [3:0]  s_pprot3;
    logic [1:0]  s_pstrb3;
    logic [23:0] s3_prdata;
    logic [2:0]  s3_pready, s3_pslverr;

    int checks   = 0;
    int failures = 0;

    apb_slave_router #(.NUM_SLV(4), .TIMEOUT(4)) u_dut (
        .pclk(pclk), .prst(prst),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pprot(m_pprot), .m_pstrb(m_pstrb),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pprot(s_pprot), .s_pstrb(s_pstrb),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr)
    );

    apb_slave_router #(.NUM_SLV(3), .TIMEOUT(4)) u_dut3 (
        .pclk(pclk), .prst(prst),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pprot(m_pprot), .m_pstrb(m_pstrb),
        .m_prdata(m_prdata3), .m_pready(m_pready3), .m_pslverr(m_pslverr3),
        .s_psel(s_psel3), .s_penable(s_penable3), .s_pwrite(s_pwrite3),
        .s_paddr(s_paddr3), .s_pwdata(s_pwdata3), .s_pprot(s_pprot3), .s_pstrb(s_pstrb3),
        .s_prdata(s3_prdata), .s_pready(s3_pready), .s_pslverr(s3_pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        m_psel    = 1'b1;
        m_penable = 1'b0;
        m_pwrite  = wr;
        m_paddr   = addr;
        m_pwdata  = wdata;
    endtask

    task automatic idle_master();
        m_psel    = 1'b0;
        m_penable = 1'b0;
    endtask

    initial begin
        prst       = 1'b1;
        m_psel     = 1'b0;
        m_penable  = 1'b0;
        m_pwrite   = 1'b0;
        m_paddr    = 8'h00;
        m_pwdata   = 8'h00;
        m_pprot    = 4'h2;
        m_pstrb    = 2'b11;
        s_prdata   = {8'h3C, 8'h11, 8'hFF, 8'h22};
        s_pready   = 4'b0000;
        s_pslverr  = 4'b0000;
        s3_prdata  = 24'h5A5A5A;
        s3_pready  = 3'b111;
        s3_pslverr = 3'b000;

        tick();
        tick();
        chk("rst_m_pready", 32'(m_pready), 32'h0);
        chk("rst_m_prdata", 32'(m_prdata), 32'h0);
        chk("rst_m_pslverr", 32'(m_pslverr), 32'h0);
        chk("rst_s_psel", 32'(s_psel), 32'h0);
        chk("rst_s_bus", 32'({s_penable, s_pwrite, s_paddr, s_pwdata, s_pprot, s_pstrb}), 32'h0);
        prst = 1'b0;
        tick();

        // Zero-wait write to slave 1; master misbehaves after setup.
        s_pready = 4'b0010;
        setup(1'b1, 8'h45, 8'hA5);
        tick();
        chk("wr_t1_s_psel", 32'(s_psel), 32'h2);
        chk("wr_t1_s_penable", 32'(s_penable), 32'h0);
        chk("wr_t1_s_pwdata", 32'(s_pwdata), 32'hA5);
        chk("wr_t1_s_paddr", 32'(s_paddr), 32'h45);
        chk("wr_t1_s_pstrb", 32'(s_pstrb), 32'h3);
        chk("wr_t1_s_pprot", 32'(s_pprot), 32'h2);
        m_penable = 1'b1;
        m_paddr   = 8'hFF;
        m_pwdata  = 8'h00;
        tick();
        chk("wr_t2_s_penable", 32'(s_penable), 32'h1);
        chk("wr_t2_m_pready", 32'(m_pready), 32'h0);
        chk("wr_t2_s_pwdata_held", 32'(s_pwdata), 32'hA5);
        chk("wr_t2_s_paddr_held", 32'(s_paddr), 32'h45);
        tick();
        chk("wr_t3_m_pready", 32'(m_pready), 32'h1);
        chk("wr_t3_m_pslverr", 32'(m_pslverr), 32'h0);
        chk("wr_t3_s_psel", 32'(s_psel), 32'h0);
        chk("wr_t3_s_penable", 32'(s_penable), 32'h0);
        $display("xfer write addr=45 data=a5 slave=1 waits=0");
        idle_master();
        tick();
        chk("wr_t4_m_pready", 32'(m_pready), 32'h0);

        // Read from slave 3 with 3 wait states; slave 1 ready/error must be ignored.
        s_pready  = 4'b0010;
        s_pslverr = 4'b0010;
        setup(1'b0, 8'hC4, 8'h77);
        tick();
        chk("rd_t1_s_psel", 32'(s_psel), 32'h8);
        chk("rd_t1_s_pstrb", 32'(s_pstrb), 32'h0);
        chk("rd_t1_s_pwrite", 32'(s_pwrite), 32'h0);
        m_penable = 1'b1;
        tick();
        chk("rd_t2_s_penable", 32'(s_penable), 32'h1);
        tick();
        tick();
        chk("rd_t4_m_pready", 32'(m_pready), 32'h0);
        chk("rd_t4_s_psel", 32'(s_psel), 32'h8);
        chk("rd_t4_s_penable", 32'(s_penable), 32'h1);
        tick();
        s_pready = 4'b1010;
        tick();
        chk("rd_t6_m_pready", 32'(m_pready), 32'h1);
        chk("rd_t6_m_prdata", 32'(m_prdata), 32'h3C);
        chk("rd_t6_m_pslverr", 32'(m_pslverr), 32'h0);
        chk("rd_t6_s_pstrb", 32'(s_pstrb), 32'h0);
        $display("xfer read addr=c4 slave=3 waits=3 rdata=%0h", m_prdata);
        idle_master();
        s_pready  = 4'b0000;
        s_pslverr = 4'b0000;
        tick();
        chk("rd_t7_m_pready", 32'(m_pready), 32'h0);
        chk("rd_t7_m_prdata_hold", 32'(m_prdata), 32'h3C);

        // Slave 0 error, then back-to-back clean read from slave 0.
        s_pready  = 4'b0001;
        s_pslverr = 4'b0001;
        setup(1'b1, 8'h12, 8'h5E);
        tick();
        chk("err_t1_s_psel", 32'(s_psel), 32'h1);
        m_penable = 1'b1;
        tick();
        tick();
        chk("err_t3_m_pready", 32'(m_pready), 32'h1);
        chk("err_t3_m_pslverr", 32'(m_pslverr), 32'h1);
        chk("err_t3_m_prdata", 32'(m_prdata), 32'h0);
        $display("xfer write addr=12 slave=0 pslverr=%0d", m_pslverr);
        tick();
        s_pslverr = 4'b0000;
        setup(1'b0, 8'h01, 8'h00);
        chk("b2b_t0_m_pready", 32'(m_pready), 32'h0);
        chk("b2b_t0_m_pslverr_hold", 32'(m_pslverr), 32'h1);
        tick();
        chk("b2b_t1_s_psel", 32'(s_psel), 32'h1);
        m_penable = 1'b1;
        tick();
        tick();
        chk("b2b_t3_m_pready", 32'(m_pready), 32'h1);
        chk("b2b_t3_m_pslverr", 32'(m_pslverr), 32'h0);
        chk("b2b_t3_m_prdata", 32'(m_prdata), 32'h22);
        chk("b2b_t3_d3_m_prdata", 32'(m_prdata3), 32'h5A);
        $display("xfer read addr=01 slave=0 back-to-back rdata=%0h", m_prdata);
        idle_master();
        s_pready = 4'b0000;
        tick();

        // Unmapped address on the 3-slave router.
        s_pready = 4'b1111;
        setup(1'b0, 8'hC0, 8'h00);
        tick();
        chk("unm_t1_m_pready", 32'(m_pready3), 32'h1);
        chk("unm_t1_m_pslverr", 32'(m_pslverr3), 32'h1);
        chk("unm_t1_m_prdata", 32'(m_prdata3), 32'h0);
        chk("unm_t1_s_psel", 32'(s_psel3), 32'h0);
        m_penable = 1'b1;
        tick();
        chk("unm_t2_m_pready", 32'(m_pready3), 32'h0);
        chk("unm_t2_s_psel", 32'(s_psel3), 32'h0);
        chk("unm_t2_s_penable", 32'(s_penable3), 32'h0);
        tick();
        chk("map_t3_m_prdata", 32'(m_prdata), 32'h3C);
        $display("xfer read addr=c0 unmapped on 3-slave router");
        idle_master();
        s_pready = 4'b0000;
        tick();

        // Reset in the middle of ACCESS, then a normal transfer.
        setup(1'b1, 8'h40, 8'h99);
        tick();
        m_penable = 1'b1;
        tick();
        chk("rsta_t2_s_psel", 32'(s_psel), 32'h2);
        chk("rsta_t2_s_penable", 32'(s_penable), 32'h1);
        prst = 1'b1;
        idle_master();
        tick();
        chk("rsta_m_pready", 32'(m_pready), 32'h0);
        chk("rsta_m_prdata", 32'(m_prdata), 32'h0);
        chk("rsta_s_psel", 32'(s_psel), 32'h0);
        chk("rsta_s_bus", 32'({s_penable, s_pwrite, s_paddr, s_pwdata, s_pprot, s_pstrb}), 32'h0);
        prst = 1'b0;
        tick();
        s_pready = 4'b0010;
        setup(1'b1, 8'h40, 8'h99);
        tick();
        chk("post_t1_s_psel", 32'(s_psel), 32'h2);
        m_penable = 1'b1;
        tick();
        tick();
        chk("post_t3_m_pready", 32'(m_pready), 32'h1);
        chk("post_t3_m_pslverr", 32'(m_pslverr), 32'h0);
        $display("xfer write addr=40 after mid-access reset");
        idle_master();
        s_pready = 4'b0000;
        tick();

`ifdef APB_ROUTER_TIMEOUT_EN
        // Slave 1 never ready: watchdog aborts after 4 ACCESS cycles.
        setup(1'b1, 8'h40, 8'h11);
        tick();
        m_penable = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("to_t5_s_penable", 32'(s_penable), 32'h1);
        chk("to_t5_m_pready", 32'(m_pready), 32'h0);
        tick();
        chk("to_t6_m_pready", 32'(m_pready), 32'h1);
        chk("to_t6_m_pslverr", 32'(m_pslverr), 32'h1);
        chk("to_t6_s_penable", 32'(s_penable), 32'h0);
        chk("to_t6_s_psel", 32'(s_psel), 32'h0);
        $display("xfer write addr=40 watchdog abort");
        idle_master();
        tick();

        // Ready arrives exactly on the threshold cycle.
        setup(1'b0, 8'h40, 8'h00);
        tick();
        m_penable = 1'b1;
        tick();
        tick();
        tick();
        tick();
        s_pready = 4'b0010;
        tick();
        chk("thr_t6_m_pready", 32'(m_pready), 32'h1);
        chk("thr_t6_m_pslverr", 32'(m_pslverr), 32'h0);
        chk("thr_t6_m_prdata", 32'(m_prdata), 32'hFF);
        $display("xfer read addr=40 ready on threshold rdata=%0h", m_prdata);
        idle_master();
        s_pready = 4'b0000;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
